i2s_dac_tx: RTL and testbench

//  I2S playback transmitter: serializes stereo 24-bit headphone samples onto the codec DAC data pin (AC_GPIO0).

---
 rtl/i2s_pkg.sv | 20 ++
 rtl/i2s_tx_fifo.sv | 63 ++++++
 rtl/i2s_dac_tx.sv | 164 ++++++++++++++++
 tb/tb_i2s_dac_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants, frame type and serializer states for the I2S DAC transmitter
package i2s_pkg;
   localparam int SAMPLE_W    = 24;
   localparam int SLOT_W      = 32;
   localparam int FIFO_DEPTH  = 2;
   localparam int SYNC_STAGES = 2;
   localparam int PAD_W       = SLOT_W - SAMPLE_W;
   localparam int BITCNT_W    = $clog2(SLOT_W + 1);

   typedef struct packed {
      logic [SAMPLE_W-1:0] left;
      logic [SAMPLE_W-1:0] right;
   } frame_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } state_t;
endpackage

// File: rtl/i2s_tx_fifo.sv
// rtl/i2s_tx_fifo.sv - synchronous stereo-frame FIFO with sync active-high reset
module i2s_tx_fifo import i2s_pkg::*; #(
   parameter int DEPTH = FIFO_DEPTH,
   parameter int WIDTH = 2 * SAMPLE_W
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [WIDTH-1:0]             wdata_i,
   output logic [WIDTH-1:0]             rdata_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full, do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end
endmodule

// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - I2S DAC serializer slaved to codec BCLK/LRCLK; I2S_TX_UNDERRUN_REPEAT_EN repeats last frame on underrun
module i2s_dac_tx import i2s_pkg::*; (
   input  logic                clk,
   input  logic                reset,
   input  logic                bclk_in,
   input  logic                lrclk_in,
   input  logic                enable,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [SAMPLE_W-1:0] s_left,
   input  logic [SAMPLE_W-1:0] s_right,
   output logic                sdata_out,
   output logic                frame_start,
   output logic                underrun
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [SYNC_STAGES-1:0] bclk_sync_q, lrclk_sync_q;
   logic                   bclk_prev_q, lr_last_q, lr_last_d;
   logic                   bclk_s, lrclk_s, bclk_fall, boundary;

   state_t                 state_q, state_d;
   logic                   left_bnd, right_bnd, pop, starve;

   frame_t                 in_frame, fifo_frame, alt_frame, load_frame;
   logic                   fifo_empty, fifo_full, push;
   logic [CNT_W-1:0]       fifo_count;

   logic [SLOT_W-1:0]      shreg_q, shreg_d;
   logic [SAMPLE_W-1:0]    r_hold_q, r_hold_d;
   logic [BITCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic                   sdata_q, sdata_d, frame_start_q, underrun_q;

   assign in_frame.left  = s_left;
   assign in_frame.right = s_right;
   assign fifo_full      = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign s_ready        = !reset && !fifo_full;
   assign push           = s_valid && s_ready;

   i2s_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2 * SAMPLE_W)) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (in_frame),
      .rdata_o (fifo_frame),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Both codec clocks see the same synchronizer depth so an LRCLK edge lines up with its BCLK fall.
   assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
   assign lrclk_s   = lrclk_sync_q[SYNC_STAGES-1];
   assign bclk_fall = bclk_prev_q && !bclk_s;
   assign boundary  = bclk_fall && (lrclk_s != lr_last_q);
   assign lr_last_d = bclk_fall ? lrclk_s : lr_last_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         bclk_sync_q  <= '0;
         lrclk_sync_q <= '0;
         bclk_prev_q  <= 1'b0;
         lr_last_q    <= 1'b0;
      end else begin
         bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], bclk_in};
         lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], lrclk_in};
         bclk_prev_q  <= bclk_s;
         lr_last_q    <= lr_last_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (boundary) begin
         if (!lrclk_s) begin
            state_d = ST_LEFT;
         end else if (state_q != ST_IDLE) begin
            state_d = ST_RIGHT;
         end
      end
   end

   // A right slot seen straight out of IDLE has no frame behind it, so it is ignored.
   always_comb begin
      left_bnd  = boundary && !lrclk_s;
      right_bnd = boundary && lrclk_s && (state_q != ST_IDLE);
      pop       = left_bnd && enable && !fifo_empty;
      starve    = left_bnd && enable && fifo_empty;
   end

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
   frame_t last_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= '0;
      end else if (pop) begin
         last_q <= fifo_frame;
      end
   end

   assign alt_frame = last_q;
`else
   assign alt_frame = '0;
`endif

   assign load_frame = pop ? fifo_frame : (starve ? alt_frame : '0);

   // The boundary fall drives the I2S one-bit delay slot; later falls shift out MSB first.
   always_comb begin
      shreg_d   = shreg_q;
      r_hold_d  = r_hold_q;
      bit_cnt_d = bit_cnt_q;
      sdata_d   = sdata_q;
      if (left_bnd) begin
         shreg_d   = {load_frame.left, {PAD_W{1'b0}}};
         r_hold_d  = load_frame.right;
         bit_cnt_d = '0;
         sdata_d   = 1'b0;
      end else if (right_bnd) begin
         shreg_d   = {r_hold_q, {PAD_W{1'b0}}};
         bit_cnt_d = '0;
         sdata_d   = 1'b0;
      end else if (bclk_fall) begin
         if (bit_cnt_q != BITCNT_W'(SLOT_W)) begin
            sdata_d   = shreg_q[SLOT_W-1];
            shreg_d   = {shreg_q[SLOT_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
         end else begin
            sdata_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_q       <= '0;
         r_hold_q      <= '0;
         bit_cnt_q     <= '0;
         sdata_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         shreg_q       <= shreg_d;
         r_hold_q      <= r_hold_d;
         bit_cnt_q     <= bit_cnt_d;
         sdata_q       <= sdata_d;
         frame_start_q <= left_bnd;
         underrun_q    <= starve;
      end
   end

   assign sdata_out   = sdata_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;
endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - scoreboard bench: codec BCLK/LRCLK model, frame capture, reference FIFO model
`timescale 1ns/1ps
module tb_i2s_dac_tx;
   localparam real BCLK_HALF = 162.76;

   logic        clk = 1'b0;
   logic        reset, enable, s_valid;
   logic [23:0] s_left, s_right;
   logic        s_ready, sdata_out, frame_start, underrun;
   logic        bclk, lrclk;

   int checks = 0;
   int errors = 0;

   i2s_dac_tx dut (
      .clk         (clk),
      .reset       (reset),
      .bclk_in     (bclk),
      .lrclk_in    (lrclk),
      .enable      (enable),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_left      (s_left),
      .s_right     (s_right),
      .sdata_out   (sdata_out),
      .frame_start (frame_start),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] i2s_frame(input logic [47:0] f);
      return {1'b0, f[47:24], 7'b0, 1'b0, f[23:0], 7'b0};
   endfunction

   // Codec: b is the bit position inside the 64-bit frame, advanced on each BCLK fall.
   int b = 63;
   initial begin
      bclk  = 1'b1;
      lrclk = 1'b1;
      forever begin
         #(BCLK_HALF);
         bclk  = 1'b0;
         b     = (b + 1) % 64;
         lrclk = (b >= 32);
         #(BCLK_HALF);
         bclk  = 1'b1;
      end
   end

   logic [63:0] cap_bits, done_bits;
   int          done_cnt = 0;
   always @(posedge bclk) begin
      cap_bits[63-b] = sdata_out;
      if (b == 63) begin
         done_bits = cap_bits;
         done_cnt++;
      end
   end

   logic [47:0] model_q[$];
   logic [63:0] exp_q[$];
   logic [47:0] last_f, pend_f, f;
   logic        pend, en_prev;
   int          seen_cnt, last_rst;

   always @(negedge clk) begin
      if (reset) begin
         model_q.delete();
         exp_q.delete();
         pend     = 1'b0;
         last_f   = '0;
         seen_cnt = done_cnt;
         last_rst = done_cnt;
      end else begin
         if (done_cnt != seen_cnt) begin
            seen_cnt = done_cnt;
            if (done_cnt - 1 > last_rst) begin
               if (exp_q.size() > 0) check_eq("frame_data", done_bits, exp_q.pop_front());
               else                  check_eq("idle_frame", done_bits, 64'd0);
            end
         end
         if (frame_start) begin
            if (!en_prev) begin
               f = '0;
               check_eq("underrun_disabled", underrun, 0);
            end else if (model_q.size() > 0) begin
               f      = model_q.pop_front();
               last_f = f;
               check_eq("underrun_with_data", underrun, 0);
            end else begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
               f = last_f;
`else
               f = '0;
`endif
               check_eq("underrun_empty", underrun, 1);
            end
            exp_q.push_back(i2s_frame(f));
         end else if (underrun) begin
            check_eq("underrun_without_frame_start", underrun, 0);
         end
         if (pend) model_q.push_back(pend_f);
         pend = 1'b0;
         if (s_valid && s_ready) begin
            pend   = 1'b1;
            pend_f = {s_left, s_right};
         end
      end
      en_prev = enable;
   end

   task automatic push(input logic [23:0] l, input logic [23:0] r, input bit expect_reopen);
      int n = 0;
      bit waited = 0;
      s_valid = 1'b1;
      s_left  = l;
      s_right = r;
      @(negedge clk);
      while (!s_ready && n < 5000) begin
         waited = 1;
         n++;
         @(negedge clk);
      end
      if (!s_ready) begin
         check_eq("push_timeout", s_ready, 1);
      end else if (expect_reopen) begin
         check_eq("sready_low_while_full", waited, 1);
         check_eq("sready_reopen_at_pop", frame_start, 1);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic wait_fs();
      int n = 0;
      @(negedge clk);
      while (!frame_start && n < 5000) begin
         n++;
         @(negedge clk);
      end
      if (!frame_start) check_eq("frame_start_timeout", frame_start, 1);
      @(posedge clk); #1;
   endtask

   task automatic wait_b(input int k);
      int n = 0;
      @(negedge clk);
      while (b != k && n < 5000) begin
         n++;
         @(negedge clk);
      end
      if (b != k) check_eq("bclk_position_timeout", b, k);
      @(posedge clk); #1;
   endtask

   initial begin
      reset   = 1'b1;
      enable  = 1'b1;
      s_valid = 1'b0;
      s_left  = '0;
      s_right = '0;
      repeat (3) @(posedge clk);
      wait_b(40);
      @(negedge clk);
      check_eq("reset_sdata", sdata_out, 0);
      check_eq("reset_sready", s_ready, 0);
      check_eq("reset_frame_start", frame_start, 0);
      check_eq("reset_underrun", underrun, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_eq("sready_after_reset", s_ready, 1);
      @(posedge clk); #1;

      // release mid right slot, first left slot carries the first frame
      push(24'hA5A5A5, 24'h5A5A5A, 0);
      wait_fs();
      push(24'h123456, 24'h654321, 0);
      wait_fs();
      wait_fs();
      wait_fs();

      // back-to-back pushes fill the FIFO
      push(24'h111111, 24'h222222, 0);
      push(24'h333333, 24'h444444, 0);
      @(negedge clk);
      check_eq("sready_full", s_ready, 0);
      @(posedge clk); #1;
      push(24'h777777, 24'h888888, 1);
      wait_fs();
      wait_fs();

      // reset in the middle of a right slot with a frame still queued
      push(24'hFFFFFF, 24'hFFFFFF, 0);
      push(24'h0F0F0F, 24'hF0F0F0, 0);
      wait_fs();
      wait_b(40);
      repeat (8) @(posedge clk);
      @(negedge clk);
      check_eq("pre_reset_sdata", sdata_out, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("sdata_after_reset", sdata_out, 0);
      check_eq("sready_in_reset", s_ready, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_eq("sready_after_midslot_reset", s_ready, 1);
      @(posedge clk); #1;
      wait_fs();

      // disabled: queued frames held, silence sent
      enable = 1'b0;
      push(24'hABCDEF, 24'hFEDCBA, 0);
      push(24'h135790, 24'h097531, 0);
      wait_fs();
      @(negedge clk);
      check_eq("sready_held_full_1", s_ready, 0);
      @(posedge clk); #1;
      wait_fs();
      @(negedge clk);
      check_eq("sready_held_full_2", s_ready, 0);
      @(posedge clk); #1;
      enable = 1'b1;
      wait_fs();
      wait_fs();
      wait_fs();
      wait_fs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
